// File: rtl/fifo_write_job_arbiter.sv
// fifo_write_job_arbiter: shares one fifo_write_interface write engine among
// NUM_REQ requesters. Picks a job, latches its config, pulses eng_start, waits
// for eng_done and returns a one-cycle req_done (with req_err for count = 0).
// Arbitration is round-robin by default; define FIXED_PRIORITY_EN for fixed
// lowest-index-wins priority.
module fifo_write_job_arbiter #(
    parameter int unsigned NUM_REQ            = 4,
    parameter int unsigned NUM_ELEMENTS_WIDTH = 16
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [32*NUM_REQ-1:0]                 req_addr,
    input  logic [NUM_ELEMENTS_WIDTH*NUM_REQ-1:0] req_num,
    output logic [NUM_REQ-1:0]                    req_grant,
    output logic [NUM_REQ-1:0]                    req_done,
    output logic [NUM_REQ-1:0]                    req_err,
    output logic [31:0]                           eng_addr_offset,
    output logic [NUM_ELEMENTS_WIDTH-1:0]         eng_num_elements,
    output logic                                  eng_start,
    input  logic                                  eng_busy,
    input  logic                                  eng_done,
    input  logic                                  eng_rst_busy,
    output logic [$clog2(NUM_REQ)-1:0]            eng_sel
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned NW    = NUM_ELEMENTS_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_REJECT = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic                 start_q, start_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [31:0]          addr_q, addr_d;
    logic [NW-1:0]        num_q, num_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    int unsigned          cand;

    // Winner selection over the live req vector
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
`ifdef FIXED_PRIORITY_EN
        // Scan downwards so the lowest set index is the last one written
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
`else
        // Scan offsets NUM_REQ..1 so the nearest one after last_grant wins
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            cand = (32'(last_grant_q) + k) % NUM_REQ;
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        done_d       = '0;
        err_d        = '0;
        start_d      = 1'b0;
        sel_d        = sel_q;
        addr_d       = addr_q;
        num_d        = num_q;
        last_grant_d = last_grant_q;

        case (state_q)
            ST_IDLE: begin
                // A pending req_done marks the mandatory gap cycle before a new latch
                if (win_found && !eng_busy && !eng_rst_busy && (done_q == '0)) begin
                    sel_d   = win_idx;
                    addr_d  = req_addr[32*32'(win_idx) +: 32];
                    num_d   = req_num[NW*32'(win_idx) +: NW];
                    grant_d = NUM_REQ'(1) << win_idx;
                    if (req_num[NW*32'(win_idx) +: NW] == '0) begin
                        state_d = ST_REJECT;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                start_d = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (eng_done) begin
                    grant_d      = '0;
                    done_d       = NUM_REQ'(1) << sel_q;
                    last_grant_d = sel_q;
                    state_d      = ST_IDLE;
                end
            end
            ST_REJECT: begin
                grant_d      = '0;
                done_d       = NUM_REQ'(1) << sel_q;
                err_d        = NUM_REQ'(1) << sel_q;
                last_grant_d = sel_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            done_q       <= '0;
            err_q        <= '0;
            start_q      <= 1'b0;
            sel_q        <= '0;
            addr_q       <= '0;
            num_q        <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            err_q        <= err_d;
            start_q      <= start_d;
            sel_q        <= sel_d;
            addr_q       <= addr_d;
            num_q        <= num_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign req_grant        = grant_q;
    assign req_done         = done_q;
    assign req_err          = err_q;
    assign eng_start        = start_q;
    assign eng_sel          = sel_q;
    assign eng_addr_offset  = addr_q;
    assign eng_num_elements = num_q;

endmodule

// File: tb/tb_fifo_write_job_arbiter.sv
// Directed bench for fifo_write_job_arbiter (NUM_REQ=4, 16-bit counts).
// Honours FIXED_PRIORITY_EN the same way as the design.
module tb_fifo_write_job_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned NW = 16;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [N-1:0]      req;
    logic [32*N-1:0]   req_addr;
    logic [NW*N-1:0]   req_num;
    logic [N-1:0]      req_grant, req_done, req_err;
    logic [31:0]       eng_addr_offset;
    logic [NW-1:0]     eng_num_elements;
    logic              eng_start;
    logic              eng_busy, eng_done, eng_rst_busy;
    logic [1:0]        eng_sel;

    int vecs  = 0;
    int miss  = 0;
    int starts = 0;

    fifo_write_job_arbiter #(.NUM_REQ(N), .NUM_ELEMENTS_WIDTH(NW)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .req              (req),
        .req_addr         (req_addr),
        .req_num          (req_num),
        .req_grant        (req_grant),
        .req_done         (req_done),
        .req_err          (req_err),
        .eng_addr_offset  (eng_addr_offset),
        .eng_num_elements (eng_num_elements),
        .eng_start        (eng_start),
        .eng_busy         (eng_busy),
        .eng_done         (eng_done),
        .eng_rst_busy     (eng_rst_busy),
        .eng_sel          (eng_sel)
    );

    always #5 aclk = ~aclk;

    // Count engine start pulses
    always @(posedge aclk) begin
        if (eng_start) starts <= starts + 1;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serve one job: wait for grant, check config and single start, complete it
    task automatic run_job(input int idx, input logic [31:0] addr, input logic [NW-1:0] num);
        int n;
        int s0;
        n = 0;
        while (req_grant == '0 && n < 30) begin
            tick();
            n++;
        end
        chk("job_grant_timeout", 64'(n < 30), 64'(1));
        chk("job_grant", 64'(req_grant), 64'(4'(1) << idx));
        chk("job_sel", 64'(eng_sel), 64'(idx));
        chk("job_addr", 64'(eng_addr_offset), 64'(addr));
        chk("job_num", 64'(eng_num_elements), 64'(num));
        s0 = starts;
        tick();
        chk("job_start", 64'(eng_start), 64'(1));
        tick();
        chk("job_start_once", 64'(eng_start), 64'(0));
        chk("job_hold_addr", 64'(eng_addr_offset), 64'(addr));
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("job_done", 64'(req_done), 64'(4'(1) << idx));
        chk("job_err", 64'(req_err), 64'(0));
        chk("job_grant_off", 64'(req_grant), 64'(0));
        chk("job_nstart", 64'(starts - s0), 64'(1));
        tick();
        chk("job_gap", 64'(req_grant), 64'(0));
        chk("job_done_pulse", 64'(req_done), 64'(0));
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    initial begin
        int s0;
        aresetn = 1'b0; req = '0; req_addr = '0; req_num = '0;
        eng_busy = 1'b0; eng_done = 1'b0; eng_rst_busy = 1'b0;
        tick();
        tick();
        // Reset values
        chk("rst_grant", 64'(req_grant), 64'(0));
        chk("rst_done", 64'(req_done), 64'(0));
        chk("rst_start", 64'(eng_start), 64'(0));
        chk("rst_addr", 64'(eng_addr_offset), 64'(0));
        chk("rst_sel", 64'(eng_sel), 64'(0));
        aresetn = 1'b1;
        tick();

        // Stray eng_done in IDLE is ignored
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();
        chk("stray_done", 64'(req_done), 64'(0));

        // Test 1: single job; req data change mid-job ignored
        req_addr[31:0] = 32'h1000;
        req_num[15:0]  = 16'd300;
        req = 4'b0001;
        tick();
        req_addr[31:0] = 32'hDEAD;
        req_num[15:0]  = 16'd1;
        chk("t1_grant", 64'(req_grant), 64'(1));
        chk("t1_addr", 64'(eng_addr_offset), 64'h1000);
        chk("t1_num", 64'(eng_num_elements), 64'(300));
        tick();
        chk("t1_start", 64'(eng_start), 64'(1));
        tick();
        tick();
        chk("t1_hold_num", 64'(eng_num_elements), 64'(300));
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        req = '0;
        chk("t1_done", 64'(req_done), 64'(1));
        chk("t1_err", 64'(req_err), 64'(0));
        tick();
        chk("t1_addr_after", 64'(eng_addr_offset), 64'h1000);

        // Test 2: all four request from reset -> 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_addr[32*i +: 32] = 32'h100 * (i + 1);
            req_num[16*i +: 16]  = 16'(5 + i);
        end
        req = 4'b1111;
`ifdef FIXED_PRIORITY_EN
        for (int j = 0; j < 5; j++) run_job(0, 32'h100, 16'd5);
`else
        for (int j = 0; j < 5; j++) run_job(j % 4, 32'h100 * ((j % 4) + 1), 16'(5 + (j % 4)));
`endif
        req = '0;
        tick();
        tick();

        // Test 3: zero count rejected two cycles after request, no start
        s0 = starts;
        req_num[32 +: 16] = 16'd0;
        req = 4'b0100;
        tick();
        chk("t3_grant", 64'(req_grant), 64'(4'b0100));
        chk("t3_done_early", 64'(req_done), 64'(0));
        tick();
        req = '0;
        chk("t3_done", 64'(req_done), 64'(4'b0100));
        chk("t3_err", 64'(req_err), 64'(4'b0100));
        chk("t3_grant_off", 64'(req_grant), 64'(0));
        tick();
        tick();
        chk("t3_nostart", 64'(starts - s0), 64'(0));

        // Test 4: eng_busy then eng_rst_busy block the launch
        s0 = starts;
        req_addr[32 +: 32] = 32'h2222;
        req_num[16 +: 16]  = 16'd9;
        eng_busy = 1'b1;
        req = 4'b0010;
        repeat (3) tick();
        chk("t4_busy_block", 64'(req_grant), 64'(0));
        eng_busy = 1'b0;
        eng_rst_busy = 1'b1;
        repeat (10) tick();
        chk("t4_rstbusy_block", 64'(req_grant), 64'(0));
        chk("t4_rstbusy_nostart", 64'(starts - s0), 64'(0));
        eng_rst_busy = 1'b0;
        tick();
        chk("t4_latch", 64'(req_grant), 64'(4'b0010));
        chk("t4_start_early", 64'(eng_start), 64'(0));
        tick();
        chk("t4_start", 64'(eng_start), 64'(1));
        chk("t4_addr", 64'(eng_addr_offset), 64'h2222);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        req = '0;
        chk("t4_done", 64'(req_done), 64'(4'b0010));
        tick();

        // Test 5: reset in RUN drops the job, requester 0 first afterwards
        req_num[16*3 +: 16] = 16'd4;
        req = 4'b1000;
        tick();
        tick();
        chk("t5_start", 64'(eng_start), 64'(1));
        aresetn = 1'b0;
        tick();
        chk("t5_grant", 64'(req_grant), 64'(0));
        chk("t5_done", 64'(req_done), 64'(0));
        chk("t5_addr", 64'(eng_addr_offset), 64'(0));
        chk("t5_num", 64'(eng_num_elements), 64'(0));
        aresetn = 1'b1;
        req = 4'b1111;
        run_job(0, 32'h100, 16'd5);
        req = '0;
        tick();
        do_reset();

        // Test 6: req[0] and req[3] held
        req = 4'b1001;
`ifdef FIXED_PRIORITY_EN
        for (int j = 0; j < 3; j++) run_job(0, 32'h100, 16'd5);
`else
        run_job(0, 32'h100, 16'd5);
        run_job(3, 32'h400, 16'd4);
        run_job(0, 32'h100, 16'd5);
`endif
        req = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
